cp0_regfile: RTL and testbench

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_regfile.sv | 127 ++++++++++++
 tb/tb_cp0_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// MIPS coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause and EPC,
// with exception commit, ERET, timer interrupt and interrupt-pending outputs.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter bit          COUNT_DIV2 = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_rdata,
    input  logic        wr_exp,
    input  logic [4:0]  exp_code,
    input  logic [31:0] exp_epc,
    input  logic        in_delayslot,
    input  logic        badvaddr_we,
    input  logic [31:0] badvaddr,
    input  logic        clear_exl,
    input  logic [5:0]  hw_int,
    output logic [31:0] epc_out,
    output logic        allow_int,
    output logic [7:0]  interrupt_flag
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc_code;
    logic [31:0] epc;
    logic [31:0] bad_vaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    // MTC0 is applied first so that exception, ERET and BadVAddr strobes
    // later in the block override it field by field.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_im      <= STATUS_RST[15:8];
            status_exl     <= STATUS_RST[1];
            status_ie      <= STATUS_RST[0];
            cause_bd       <= 1'b0;
            cause_ti       <= 1'b0;
            cause_ip       <= 8'h00;
            cause_exc_code <= 5'h00;
            epc            <= 32'h0;
            bad_vaddr      <= 32'h0;
            count          <= 32'h0;
            compare        <= 32'h0;
            tick           <= 1'b0;
        end else begin
            tick <= ~tick;
            if (!COUNT_DIV2 || tick)
                count <= count + 32'd1;
            if (count == compare)
                cause_ti <= 1'b1;
            cause_ip[7]   <= hw_int[5] | cause_ti;
            cause_ip[6:2] <= hw_int[4:0];

            if (mtc0_we) begin
                case (mtc0_addr)
                    ADDR_BADVADDR: bad_vaddr <= mtc0_wdata;
                    ADDR_COUNT: begin
                        count <= mtc0_wdata;
                        tick  <= 1'b0;
                    end
                    ADDR_COMPARE: begin
                        compare  <= mtc0_wdata;
                        cause_ti <= 1'b0;
                    end
                    ADDR_STATUS: begin
                        status_im  <= mtc0_wdata[15:8];
                        status_exl <= mtc0_wdata[1];
                        status_ie  <= mtc0_wdata[0];
                    end
                    ADDR_CAUSE: cause_ip[1:0] <= mtc0_wdata[9:8];
                    ADDR_EPC:   epc <= mtc0_wdata;
                    default: ;
                endcase
            end

            if (badvaddr_we)
                bad_vaddr <= badvaddr;
            if (clear_exl)
                status_exl <= 1'b0;
            // A nested exception keeps the original EPC/BD so ERET returns to the first victim.
            if (wr_exp) begin
                status_exl     <= 1'b1;
                cause_exc_code <= exp_code;
                if (!status_exl) begin
                    epc      <= exp_epc;
                    cause_bd <= in_delayslot;
                end
            end
        end
    end

    always_comb begin
        mfc0_rdata = 32'h0;
        case (mfc0_addr)
            ADDR_BADVADDR: mfc0_rdata = bad_vaddr;
            ADDR_COUNT:    mfc0_rdata = count;
            ADDR_COMPARE:  mfc0_rdata = compare;
            ADDR_STATUS:   mfc0_rdata = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
            ADDR_CAUSE:    mfc0_rdata = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc_code, 2'b0};
            ADDR_EPC:      mfc0_rdata = epc;
            default:       mfc0_rdata = 32'h0;
        endcase
    end

    assign epc_out        = epc;
    assign allow_int      = status_ie & ~status_exl;
    assign interrupt_flag = cause_ip & status_im;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile: reset, Status/Cause masking, exception
// commit priority, BadVAddr, interrupt latency, timer interrupt, Count wrap and reset override.
`timescale 1ns/1ps
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic        wr_exp;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc;
    logic        in_delayslot;
    logic        badvaddr_we;
    logic [31:0] badvaddr;
    logic        clear_exl;
    logic [5:0]  hw_int;
    logic [31:0] epc_out;
    logic        allow_int;
    logic [7:0]  interrupt_flag;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;

    cp0_regfile dut (
        .clk(clk), .rst(rst),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .wr_exp(wr_exp), .exp_code(exp_code), .exp_epc(exp_epc), .in_delayslot(in_delayslot),
        .badvaddr_we(badvaddr_we), .badvaddr(badvaddr), .clear_exl(clear_exl),
        .hw_int(hw_int), .epc_out(epc_out), .allow_int(allow_int), .interrupt_flag(interrupt_flag)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
        mfc0_addr = addr;
        #0.5;
        data = mfc0_rdata;
    endtask

    task automatic mtc0Write(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we = 1'b1;
        mtc0_addr = addr;
        mtc0_wdata = data;
        applyStimulus(1);
        mtc0_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0; mfc0_addr = '0;
        wr_exp = 1'b0; exp_code = '0; exp_epc = '0; in_delayslot = 1'b0;
        badvaddr_we = 1'b0; badvaddr = '0; clear_exl = 1'b0; hw_int = '0;
        applyStimulus(2);
        rst = 1'b0;

        readReg(12, rd); checkOutput("rst_status", rd, 32'h0040_0000);
        readReg(13, rd); checkOutput("rst_cause", rd, 32'h0);
        readReg(9, rd);  checkOutput("rst_count", rd, 32'h0);
        readReg(8, rd);  checkOutput("rst_badvaddr", rd, 32'h0);
        checkOutput("rst_allow_int", {31'b0, allow_int}, 32'h0);
        checkOutput("rst_int_flag", {24'b0, interrupt_flag}, 32'h0);
        checkOutput("rst_epc_out", epc_out, 32'h0);

        mtc0Write(11, 32'hFFFF_0000);
        readReg(11, rd); checkOutput("compare_rw", rd, 32'hFFFF_0000);
        mtc0Write(5, 32'h1234_5678);
        readReg(5, rd);  checkOutput("unimpl_read", rd, 32'h0);

        mtc0Write(12, 32'hFFFF_FFFF);
        readReg(12, rd); checkOutput("status_mask", rd, 32'h0040_FF03);
        checkOutput("allow_exl", {31'b0, allow_int}, 32'h0);
        mtc0Write(12, 32'h0000_0001);
        readReg(12, rd); checkOutput("status_ie", rd, 32'h0040_0001);
        checkOutput("allow_ie", {31'b0, allow_int}, 32'h1);

        wr_exp = 1'b1; exp_code = 5'h0C; exp_epc = 32'hBFC0_0100; in_delayslot = 1'b1;
        applyStimulus(1);
        wr_exp = 1'b0;
        checkOutput("exp1_epc_out", epc_out, 32'hBFC0_0100);
        readReg(14, rd); checkOutput("exp1_epc_read", rd, 32'hBFC0_0100);
        readReg(13, rd); checkOutput("exp1_cause", rd, 32'h8000_0030);
        readReg(12, rd); checkOutput("exp1_status", rd, 32'h0040_0003);

        wr_exp = 1'b1; exp_code = 5'h04; exp_epc = 32'h0; in_delayslot = 1'b0;
        applyStimulus(1);
        wr_exp = 1'b0;
        checkOutput("exp2_epc_kept", epc_out, 32'hBFC0_0100);
        readReg(13, rd); checkOutput("exp2_cause", rd, 32'h8000_0010);

        clear_exl = 1'b1;
        applyStimulus(1);
        clear_exl = 1'b0;
        readReg(12, rd); checkOutput("eret_status", rd, 32'h0040_0001);
        checkOutput("eret_allow", {31'b0, allow_int}, 32'h1);

        wr_exp = 1'b1; exp_code = 5'h0A; exp_epc = 32'h0000_1234; in_delayslot = 1'b0;
        clear_exl = 1'b1;
        mtc0_we = 1'b1; mtc0_addr = 12; mtc0_wdata = 32'h0000_FF01;
        applyStimulus(1);
        wr_exp = 1'b0; clear_exl = 1'b0; mtc0_we = 1'b0;
        readReg(12, rd); checkOutput("conflict_status", rd, 32'h0040_FF03);
        checkOutput("conflict_allow", {31'b0, allow_int}, 32'h0);
        checkOutput("conflict_epc", epc_out, 32'h0000_1234);
        readReg(13, rd); checkOutput("conflict_cause", rd, 32'h0000_0028);

        mtc0Write(8, 32'h0000_0AAA);
        readReg(8, rd); checkOutput("badvaddr_mtc0", rd, 32'h0000_0AAA);
        mtc0_we = 1'b1; mtc0_addr = 8; mtc0_wdata = 32'h1111_1111;
        badvaddr_we = 1'b1; badvaddr = 32'hDEAD_BEEF;
        applyStimulus(1);
        mtc0_we = 1'b0; badvaddr_we = 1'b0;
        readReg(8, rd); checkOutput("badvaddr_prio", rd, 32'hDEAD_BEEF);

        mtc0Write(13, 32'hFFFF_FFFF);
        readReg(13, rd); checkOutput("cause_mask", rd, 32'h0000_0328);
        checkOutput("sw_int_flag", {24'b0, interrupt_flag}, 32'h0000_0003);
        hw_int = 6'b000101;
        checkOutput("hw_int_latency", {24'b0, interrupt_flag}, 32'h0000_0003);
        applyStimulus(1);
        checkOutput("hw_int_flag", {24'b0, interrupt_flag}, 32'h0000_0017);
        readReg(13, rd); checkOutput("hw_int_cause", rd, 32'h0000_1728);
        hw_int = 6'b000000;
        mtc0Write(13, 32'h0);
        checkOutput("int_cleared", {24'b0, interrupt_flag}, 32'h0);

        mtc0Write(9, 32'h0);
        mtc0Write(11, 32'd10);
        readReg(9, rd);  checkOutput("timer_count_start", rd, 32'h0);
        applyStimulus(19);
        readReg(9, rd);  checkOutput("timer_count_e20", rd, 32'd10);
        readReg(13, rd); checkOutput("timer_ti_pre", rd, 32'h0000_0028);
        applyStimulus(1);
        readReg(13, rd); checkOutput("timer_ti_set", rd, 32'h4000_0028);
        checkOutput("timer_flag_lat", {24'b0, interrupt_flag}, 32'h0);
        applyStimulus(1);
        readReg(13, rd); checkOutput("timer_ip7", rd, 32'h4000_8028);
        checkOutput("timer_flag", {24'b0, interrupt_flag}, 32'h0000_0080);
        mtc0Write(11, 32'hFFFF_0000);
        readReg(13, rd); checkOutput("timer_ti_clr", rd, 32'h0000_8028);
        applyStimulus(1);
        readReg(13, rd); checkOutput("timer_ip7_clr", rd, 32'h0000_0028);
        checkOutput("timer_flag_clr", {24'b0, interrupt_flag}, 32'h0);

        mtc0Write(9, 32'hFFFF_FFFF);
        readReg(9, rd); checkOutput("wrap_load", rd, 32'hFFFF_FFFF);
        applyStimulus(1);
        readReg(9, rd); checkOutput("wrap_hold", rd, 32'hFFFF_FFFF);
        applyStimulus(1);
        readReg(9, rd); checkOutput("wrap_zero", rd, 32'h0);

        mtc0Write(9, 32'd3);
        mtc0Write(11, 32'd3);
        applyStimulus(1);
        readReg(13, rd); checkOutput("pre_rst_ti", rd, 32'h4000_0028);
        rst = 1'b1; hw_int = 6'h3F;
        mtc0_we = 1'b1; mtc0_addr = 12; mtc0_wdata = 32'hFFFF_FFFF;
        wr_exp = 1'b1; exp_code = 5'h1F; exp_epc = 32'h0000_5555; in_delayslot = 1'b1;
        badvaddr_we = 1'b1; badvaddr = 32'h7777_7777;
        applyStimulus(1);
        rst = 1'b0; hw_int = '0; mtc0_we = 1'b0; wr_exp = 1'b0; badvaddr_we = 1'b0;
        readReg(12, rd); checkOutput("rst2_status", rd, 32'h0040_0000);
        readReg(13, rd); checkOutput("rst2_cause", rd, 32'h0);
        readReg(14, rd); checkOutput("rst2_epc", rd, 32'h0);
        readReg(8, rd);  checkOutput("rst2_badvaddr", rd, 32'h0);
        readReg(9, rd);  checkOutput("rst2_count", rd, 32'h0);
        readReg(11, rd); checkOutput("rst2_compare", rd, 32'h0);
        checkOutput("rst2_epc_out", epc_out, 32'h0);
        checkOutput("rst2_allow", {31'b0, allow_int}, 32'h0);
        checkOutput("rst2_flag", {24'b0, interrupt_flag}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
